// File: rtl/div_share_arb_pkg.sv
// rtl/div_share_arb_pkg.sv - shared types and constants for the shared-divider arbiter
package div_share_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Wide enough for any supported W; the top slices it down.
    localparam int MAX_W = 64;
    localparam logic [MAX_W-1:0] DBZ_RESULT = '1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_share_arb_rr_pick.sv
// rtl/div_share_arb_rr_pick.sv - combinational round-robin picker starting at rr_ptr
module div_share_arb_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [IW-1:0]    win_idx,
    output logic             any_req
);

    // Scan from the farthest offset down so the one nearest rr_ptr wins last.
    always_comb begin
        int j;
        win_idx = '0;
        any_req = 1'b0;
        j       = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (req[IW'(j)]) begin
                win_idx = IW'(j);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_arb.sv
// rtl/div_share_arb.sv - round-robin sequencer sharing one divider among N requesters
module div_share_arb
    import div_share_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int DIV_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_data,
    output logic               rsp_dbz,
    output logic               busy,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    output logic               ena_div,
    output logic               rst_div,
    input  logic [W-1:0]       alu_out
);

    localparam int IW = clog2(N_REQ);
    localparam int CW = clog2(DIV_LAT) + 1;

    state_t           state, state_n;
    logic [IW-1:0]    rr_ptr, rr_ptr_n;
    logic [IW-1:0]    win_q, win_q_n;
    logic [IW-1:0]    pick_idx;
    logic             any_req;
    logic [W-1:0]     op_a, op_a_n, op_b, op_b_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [W-1:0]     res_q, res_n;
    logic             dbz_q, dbz_n;
    logic [N_REQ-1:0] gnt_n, rsp_valid_n;
    logic [W-1:0]     rsp_data_n, alu_a_n, alu_b_n;
    logic             rsp_dbz_n, ena_div_n, rst_div_n;

    div_share_arb_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .win_idx (pick_idx),
        .any_req (any_req)
    );

    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        win_q_n     = win_q;
        op_a_n      = op_a;
        op_b_n      = op_b;
        cnt_n       = cnt;
        res_n       = res_q;
        dbz_n       = dbz_q;
        gnt_n       = '0;
        rsp_valid_n = '0;
        rsp_data_n  = rsp_data;
        rsp_dbz_n   = rsp_dbz;
        alu_a_n     = alu_a;
        alu_b_n     = alu_b;
        ena_div_n   = 1'b0;
        rst_div_n   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    win_q_n = pick_idx;
                    op_a_n  = req_a[pick_idx*W +: W];
                    op_b_n  = req_b[pick_idx*W +: W];
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                gnt_n = N_REQ'(1) << win_q;
                // Divide-by-zero never touches the divider.
                if (op_b == '0) begin
                    res_n   = DBZ_RESULT[W-1:0];
                    dbz_n   = 1'b1;
                    state_n = RESP;
                end else begin
                    alu_a_n   = op_a;
                    alu_b_n   = op_b;
                    ena_div_n = 1'b1;
                    rst_div_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = WAIT;
                end
            end
            WAIT: begin
                ena_div_n = 1'b1;
                rst_div_n = 1'b1;
                cnt_n     = cnt + 1'b1;
                if (cnt == CW'(DIV_LAT - 1)) begin
                    res_n   = alu_out;
                    dbz_n   = 1'b0;
                    state_n = RESP;
                end
            end
            RESP: begin
                rsp_valid_n = N_REQ'(1) << win_q;
                rsp_data_n  = res_q;
                rsp_dbz_n   = dbz_q;
                rr_ptr_n    = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            win_q     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            cnt       <= '0;
            res_q     <= '0;
            dbz_q     <= 1'b0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_dbz   <= 1'b0;
            busy      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            ena_div   <= 1'b0;
            rst_div   <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            win_q     <= win_q_n;
            op_a      <= op_a_n;
            op_b      <= op_b_n;
            cnt       <= cnt_n;
            res_q     <= res_n;
            dbz_q     <= dbz_n;
            gnt       <= gnt_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_dbz   <= rsp_dbz_n;
            busy      <= (state_n != IDLE);
            alu_a     <= alu_a_n;
            alu_b     <= alu_b_n;
            ena_div   <= ena_div_n;
            rst_div   <= rst_div_n;
        end
    end

endmodule

// File: doc/div_share_arb.md
Name: div_share_arb

Overview:
- Round-robin arbiter and sequencer that lets N requester FSMs share one divider ALU (the alu_1_a / alu_1_b / alu_1_out / ena_div / rst_div resource).
- Each requester presents one dividend/divisor pair; the block grants one, drives the divider, waits the fixed divider latency and returns the quotient to the winner only.
- Divide-by-zero requests are short-circuited and never reach the divider.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 32, operand/result width.
- DIV_LAT, 3, cycles ena_div must be held before alu_out is valid (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- req  in  N_REQ  per-requester request, level.
- req_a  in  N_REQ*W  dividends, slice i = bits [i*W +: W].
- req_b  in  N_REQ*W  divisors, same packing.
- gnt  out  N_REQ  one-hot grant pulse.
- rsp_valid  out  N_REQ  one-hot result pulse.
- rsp_data  out  W  quotient, valid with rsp_valid.
- rsp_dbz  out  1  divide-by-zero flag, valid with rsp_valid.
- busy  out  1  high whenever state != IDLE.
- alu_a  out  W  divider dividend.
- alu_b  out  W  divider divisor.
- ena_div  out  1  divider enable.
- rst_div  out  1  divider clear, active-low.
- alu_out  in  W  divider quotient.

Behaviour:
- Clock is clk; reset is rst, synchronous, active-low.
- Reset (rst==0 at a clk edge):
  - state=IDLE, rr_ptr=0, all outputs 0 (rst_div=0).
  - Any in-flight operation is abandoned; no rsp_valid is produced for it.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - rst_div=0, ena_div=0.
  - If any req bit is high, pick the first set bit scanning i = rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Latch win_idx, op_a=req_a[win], op_b=req_b[win]; go to ISSUE.
  - If no req bit is high, stay in IDLE.
- ISSUE (1 cycle):
  - gnt[win]=1.
  - If op_b==0: go to RESP with result=all-ones and dbz=1; ena_div stays 0.
  - Otherwise: alu_a=op_a, alu_b=op_b, ena_div=1, rst_div=1, cnt=0; go to WAIT.
- WAIT:
  - ena_div=1, rst_div=1; alu_a and alu_b are held stable.
  - cnt increments each cycle.
  - When cnt==DIV_LAT-1: capture alu_out into the result register, dbz=0, go to RESP. WAIT therefore lasts exactly DIV_LAT cycles.
- RESP (1 cycle):
  - rsp_valid[win]=1; rsp_data and rsp_dbz driven.
  - ena_div=0, rst_div=0.
  - rr_ptr=(win+1) mod N_REQ; go to IDLE.
- Latency:
  - Normal request: gnt occurs 2 cycles after the req-sampling edge; rsp_valid occurs DIV_LAT+1 cycles after gnt.
  - dbz request: rsp_valid occurs 1 cycle after gnt.
- Handshake:
  - Operands are sampled only at the grant decision, so they may change after gnt.
  - The requester must drop req in the cycle rsp_valid is seen. A req still high in the cycle after RESP is treated as a new request.
  - If req drops during ISSUE/WAIT, the result is still delivered.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,3,0,...
- Requests arriving while busy are ignored until IDLE.
- Simultaneous req rise and RESP: not sampled until the IDLE cycle.
- rsp_data holds its last value between pulses; rsp_valid and gnt are single-cycle pulses.
- Widths: no arithmetic beyond the cnt compare.
  - cnt width = clog2(DIV_LAT)+1.
  - rr_ptr and win_idx width = clog2(N_REQ).
- Unused rr_ptr values are impossible because the pointer wraps modulo N_REQ.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - DBZ_RESULT = all-ones of W;
  - a clog2 helper function.
- One natural sub-module, rr_pick:
  - combinational round-robin priority picker;
  - inputs req and rr_ptr; outputs win_idx and any_req.
- The state machine and datapath registers stay in div_share_arb.

Test Plan:
- Single requester:
  - Stimulus: req[1]=1, a=100, b=7, DIV_LAT=3 (divider model = a/b after 3 enabled cycles).
  - Expected: gnt[1] pulse; rsp_valid[1] 4 cycles later; rsp_data=14, rsp_dbz=0; ena_div high for exactly 4 cycles.
- Divide by zero:
  - Stimulus: req[2]=1, a=55, b=0.
  - Expected: rsp_valid[2] 1 cycle after gnt[2]; rsp_data=32'hFFFF_FFFF, rsp_dbz=1; ena_div never asserted.
- Round-robin:
  - Stimulus: req=4'b1111 held, each requester drops req on its rsp_valid and re-raises it the next cycle.
  - Expected: grant order 0,1,2,3,0,1; no requester is granted twice before all others.
- Operand capture:
  - Stimulus: req[0] a=90, b=9; change req_a[0] to 1 the cycle after gnt.
  - Expected: rsp_data=10.
- Reset mid-operation:
  - Stimulus: assert rst=0 during WAIT for one cycle.
  - Expected: next cycle busy=0, all outputs 0, no rsp_valid; a following req[3] a=8, b=2 returns 4 and is granted from rr_ptr=0.
- Late request while busy:
  - Stimulus: req[0] granted; req[1] raised during WAIT.
  - Expected: req[1] not granted until after rsp_valid[0] plus one IDLE cycle; then gnt[1] occurs.
